// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the bit stream serializer slice.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package serializer_pkg;

    // Shifter states: waiting for a buffered word, or streaming one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Width of the bit-index counter for a word of the given width.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Word-in / bit-out bundle between a word producer and the serializer.
// Latency: none (wires only).
// Backpressure: word_ready from the slave throttles word_valid from the master.
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             frame_start;
    logic             busy;

    // Word producer side.
    modport master (
        output word_in,
        output word_valid,
        input  word_ready,
        input  bit_out,
        input  bit_valid,
        input  frame_start,
        input  busy
    );

    // Serializer side.
    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready,
        output bit_out,
        output bit_valid,
        output frame_start,
        output busy
    );
endinterface

// File: rtl/word_hold_reg.sv
// Single-entry word buffer with a full flag; load fills it, take empties it.
// Latency: one cycle from load to dout/full.
// Backpressure: caller must only load while !full (load wins if both strobes are high).
module word_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    // Occupancy flag: set on load, cleared on take, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

    // Payload capture; contents are don't-care while the flag is clear.
    always_ff @(posedge clk) begin
        if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter: one WIDTH-bit word becomes WIDTH consecutive bits.
// Latency: word accepted at edge k shows its first bit after edge k+1.
// Backpressure: word_ready = !buffer_full (0 in reset); back-to-back words stream gapless.
module bit_stream_serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_stream_serializer_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] sh_adv;
    cnt_t             cnt_q, cnt_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;

    logic [WIDTH-1:0] buf_dat;
    logic             buf_full;
    logic             accept;
    logic             take;

    // The bit on the wire is always the leading end of the shift register.
    function automatic logic head(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? x[WIDTH-1] : x[0];
    endfunction

    assign bus.word_ready = !buf_full && !rst;
    assign accept         = bus.word_valid && bus.word_ready;
    assign sh_adv         = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .take (take),
        .din  (bus.word_in),
        .dout (buf_dat),
        .full (buf_full)
    );

    // Next-state logic: load from the buffer when idle or on the last bit, else advance.
    always_comb begin
        state_d       = state_q;
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        bit_out_d     = IDLE_BIT;
        bit_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        take          = 1'b0;

        // Accept needs !buf_full and load needs buf_full, so the two never collide.
        if (buf_full && (state_q == IDLE || cnt_q == LAST)) begin
            take          = 1'b1;
            state_d       = SHIFT;
            sh_d          = buf_dat;
            cnt_d         = '0;
            bit_out_d     = head(buf_dat);
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                sh_d        = sh_adv;
                cnt_d       = cnt_q + cnt_t'(1);
                bit_out_d   = head(sh_adv);
                bit_valid_d = 1'b1;
            end
        end
    end

    // State, shifter, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sh_q          <= '0;
            cnt_q         <= '0;
            bit_out_q     <= IDLE_BIT;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.bit_out     = bit_out_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state_q == SHIFT) || buf_full;

endmodule
